// File: rtl/btnflt_multi.sv
// Multi-channel push-button filter: synchronise, debounce press and release
// over CNT_FULL stable cycles, and emit press / release / long-press pulses.
//
// state   | meaning
// IDLE    | released, waiting for a synced press
// PWAIT   | counting stable pressed samples
// PRESSED | accepted press, timing long-hold periods
// RWAIT   | counting stable released samples, LEVEL still 1
module btnflt_multi #(
  parameter int              N_CH         = 4,
  parameter int              CNT_FULL     = 1_000_000,
  parameter int              LONG_PERIODS = 100,
  parameter int              SYNC_STAGES  = 2,
  parameter logic [N_CH-1:0] POLARITY     = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_CH-1:0] BTN,
  output logic [N_CH-1:0] LEVEL,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE,
  output logic [N_CH-1:0] LONG
);

  localparam int CW = $clog2(CNT_FULL + 1);
  // Keep lcnt at least one bit wide so LONG_PERIODS=0 still elaborates.
  localparam int LW = (LONG_PERIODS > 0) ? $clog2(LONG_PERIODS + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_FULL - 1);
  localparam logic [LW-1:0] LCNT_MAX = LW'(LONG_PERIODS);
  localparam bit            LONG_EN  = (LONG_PERIODS > 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PWAIT   = 2'd1,
    PRESSED = 2'd2,
    RWAIT   = 2'd3
  } state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [LW-1:0]          lcnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   long_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync_q    <= '0;
        state_q   <= IDLE;
        cnt_q     <= '0;
        lcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], BTN[i] ^ POLARITY[i]};
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (state_q)
          IDLE: begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            if (s) state_q <= PWAIT;
          end
          PWAIT: begin
            if (!s) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= PRESSED;
              level_q <= 1'b1;
              press_q <= 1'b1;
              cnt_q   <= '0;
              lcnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          PRESSED: begin
            level_q <= 1'b1;
            if (!s) begin
              state_q <= RWAIT;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              // Saturation at LCNT_MAX is what limits LONG to once per press.
              if (lcnt_q != LCNT_MAX) begin
                lcnt_q <= lcnt_q + LW'(1);
                if (LONG_EN && (lcnt_q + LW'(1) == LCNT_MAX)) long_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          RWAIT: begin
            level_q <= 1'b1;
            if (s) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q   <= IDLE;
              level_q   <= 1'b0;
              release_q <= 1'b1;
              cnt_q     <= '0;
              lcnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            level_q <= 1'b0;
            cnt_q   <= '0;
            lcnt_q  <= '0;
          end
        endcase
      end
    end

    assign LEVEL[i]   = level_q;
    assign PRESS[i]   = press_q;
    assign RELEASE[i] = release_q;
    assign LONG[i]    = long_q;
  end

endmodule

// File: tb/tb_btnflt_multi.sv
// Directed bench for btnflt_multi: per-cycle vector table on a 4-channel
// instance (CNT_FULL=10, LONG_PERIODS=3, ch0 active-low) plus a CNT_FULL=1 instance.
module tb_btnflt_multi;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] BTN;
  logic [3:0] LEVEL, PRESS, RELEASE, LONG;
  logic [0:0] btn1;
  logic [0:0] level1, press1, release1, long1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  btnflt_multi #(
    .N_CH(4), .CNT_FULL(10), .LONG_PERIODS(3), .SYNC_STAGES(2), .POLARITY(4'b0001)
  ) u_dut (
    .CLK(CLK), .RST_N(RST_N), .BTN(BTN),
    .LEVEL(LEVEL), .PRESS(PRESS), .RELEASE(RELEASE), .LONG(LONG)
  );

  btnflt_multi #(
    .N_CH(1), .CNT_FULL(1), .LONG_PERIODS(2), .SYNC_STAGES(3), .POLARITY(1'b0)
  ) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .BTN(btn1),
    .LEVEL(level1), .PRESS(press1), .RELEASE(release1), .LONG(long1)
  );

  // Each record: drive btn, then for each of the next n cycles the outputs
  // must equal {level, press, rel, lng}.
  typedef struct {
    logic [3:0] btn;
    int         n;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  function automatic void add(input bit part_b, input logic [3:0] b, input int n,
                              input logic [3:0] l, input logic [3:0] p,
                              input logic [3:0] r, input logic [3:0] g);
    vec_t v;
    v.btn = b; v.n = n; v.level = l; v.press = p; v.rel = r; v.lng = g;
    if (part_b) tbl_b.push_back(v);
    else        tbl_a.push_back(v);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got {lvl,prs,rel,lng}=%h, expected %h", name, idx, act, exp);
    end
  endtask

  // Called just after a negedge; leaves the bench on a negedge.
  task automatic apply(input string name, input int idx, input vec_t v);
    BTN = v.btn;
    for (int k = 0; k < v.n; k++) begin
      @(negedge CLK);
      check(name, idx, {LEVEL, PRESS, RELEASE, LONG}, {v.level, v.press, v.rel, v.lng});
    end
  endtask

  initial begin
    // Idle: ch0 is active-low so its idle level is 1.
    add(0, 4'b0001, 15, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch0 press (drive low): PRESS/LEVEL after edge 12, pulse gone after edge 13.
    add(0, 4'b0000, 12, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0000,  1, 4'h1, 4'h1, 4'h0, 4'h0);
    add(0, 4'b0000,  1, 4'h1, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0001, 12, 4'h1, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0001,  1, 4'h0, 4'h0, 4'h1, 4'h0);
    add(0, 4'b0001,  3, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch1 bounce 5 high / 1 low / 3 high / low: rejected.
    add(0, 4'b0011,  5, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0001,  1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0011,  3, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0001,  6, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch1 held 20 cycles.
    add(0, 4'b0011, 12, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0011,  1, 4'h2, 4'h2, 4'h0, 4'h0);
    add(0, 4'b0011,  7, 4'h2, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0001, 12, 4'h2, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0001,  1, 4'h0, 4'h0, 4'h2, 4'h0);
    add(0, 4'b0001,  3, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch2 held 60 cycles: PRESS at 12, single LONG at 42, RELEASE 12 after fall.
    add(0, 4'b0101, 12, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0101,  1, 4'h4, 4'h4, 4'h0, 4'h0);
    add(0, 4'b0101, 29, 4'h4, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0101,  1, 4'h4, 4'h0, 4'h0, 4'h4);
    add(0, 4'b0101, 17, 4'h4, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0001, 12, 4'h4, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0001,  1, 4'h0, 4'h0, 4'h4, 4'h0);
    add(0, 4'b0001,  2, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch3 release bounce at edges 26..29: lcnt=1 survives, LONG at edge 52.
    add(0, 4'b1001, 12, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'b1001,  1, 4'h8, 4'h8, 4'h0, 4'h0);
    add(0, 4'b1001, 13, 4'h8, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0001,  4, 4'h8, 4'h0, 4'h0, 4'h0);
    add(0, 4'b1001, 22, 4'h8, 4'h0, 4'h0, 4'h0);
    add(0, 4'b1001,  1, 4'h8, 4'h0, 4'h0, 4'h8);
    add(0, 4'b1001,  5, 4'h8, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0001, 12, 4'h8, 4'h0, 4'h0, 4'h0);
    add(0, 4'b0001,  1, 4'h0, 4'h0, 4'h8, 4'h0);
    add(0, 4'b0001,  2, 4'h0, 4'h0, 4'h0, 4'h0);
    // All four channels pressed together.
    add(0, 4'b1110, 12, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'b1110,  1, 4'hF, 4'hF, 4'h0, 4'h0);
    add(0, 4'b1110,  5, 4'hF, 4'h0, 4'h0, 4'h0);
    // After mid-press reset: fresh qualification, then simultaneous release.
    add(1, 4'b1110, 12, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'b1110,  1, 4'hF, 4'hF, 4'h0, 4'h0);
    add(1, 4'b1110,  3, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 4'b0001, 12, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 4'b0001,  1, 4'h0, 4'h0, 4'hF, 4'h0);
    add(1, 4'b0001,  2, 4'h0, 4'h0, 4'h0, 4'h0);

    RST_N = 1'b0;
    BTN   = 4'b0001;
    btn1  = 1'b0;
    #1;
    check("reset_main", 0, {LEVEL, PRESS, RELEASE, LONG}, 16'h0000);
    check("reset_cf1", 0, {12'h000, level1, press1, release1, long1}, 16'h0000);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // CNT_FULL=1, SYNC_STAGES=3: PRESS after edge 4, LONG after edge 6, RELEASE 4 after fall.
    btn1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check("cf1_press", k, {12'h000, level1, press1, release1, long1},
            {12'h000, 1'(k >= 4), 1'(k == 4), 1'b0, 1'(k == 6)});
    end
    btn1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      check("cf1_release", k, {12'h000, level1, press1, release1, long1},
            {12'h000, 1'(k < 4), 1'b0, 1'(k == 4), 1'b0});
    end

    foreach (tbl_a[i]) apply("vec_a", i, tbl_a[i]);

    // Reset while every channel is PRESSED: outputs drop before the next edge.
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset", 0, {LEVEL, PRESS, RELEASE, LONG}, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("hold_reset", k, {LEVEL, PRESS, RELEASE, LONG}, 16'h0000);
    end
    RST_N = 1'b1;

    foreach (tbl_b[i]) apply("vec_b", i, tbl_b[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btnflt_multi.md
Name: btnflt_multi

Overview:
- Multi-channel successor to the single-button filter.
- Each channel synchronises a raw, bouncing button input, qualifies both press and release over a programmable stable time, and produces a clean level.
- Each channel also emits one-cycle press, release and long-press event pulses.
- Sits between board push-buttons and the control FSMs. Channels are independent; there is no cross-channel interaction.

Parameters:
- N_CH, 4, number of independent button channels (>=1).
- CNT_FULL, 1_000_000, consecutive stable cycles required to accept a press or a release (>=1).
- LONG_PERIODS, 100, number of CNT_FULL-cycle periods held pressed before LONG fires; 0 disables LONG.
- SYNC_STAGES, 2, depth of the input synchroniser flop chain (>=2).
- POLARITY, {N_CH{1'b0}}, per-channel input polarity: bit=1 means the button is active-low, and the input is inverted before the synchroniser.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- BTN  in  N_CH  raw asynchronous button inputs.
- LEVEL  out  N_CH  debounced button state, 1 = pressed.
- PRESS  out  N_CH  one-cycle pulse on an accepted press.
- RELEASE  out  N_CH  one-cycle pulse on an accepted release.
- LONG  out  N_CH  one-cycle pulse, at most once per press, on reaching the long-hold time.

Behaviour:
- Reset (RST_N=0): asynchronous. All synchroniser flops, counters, state and outputs clear immediately.
  - LEVEL=PRESSED... reset values: LEVEL=0, PRESS=0, RELEASE=0, LONG=0, state=IDLE.
  - Reset mid-press: no RELEASE pulse is emitted.
  - After deassertion, a held button is re-qualified from scratch.
- Input path: s[i] = (BTN[i] ^ POLARITY[i]) delayed through SYNC_STAGES flops.
- Per-channel counters:
  - cnt: width clog2(CNT_FULL+1).
  - lcnt: width clog2(LONG_PERIODS+1), saturating.
- Per-channel FSM, all outputs registered:
  - IDLE: LEVEL=0. If s=1: go to PWAIT, cnt=0.
  - PWAIT:
    - If s=0: go to IDLE, cnt=0 (glitch rejected, no pulse).
    - Otherwise cnt++.
    - On the CNT_FULL-th consecutive s=1 sample in PWAIT: go to PRESSED, set LEVEL=1, pulse PRESS, cnt=0, lcnt=0.
  - PRESSED:
    - If s=0: go to RWAIT, cnt=0; lcnt is frozen.
    - Otherwise cnt++. When cnt==CNT_FULL-1: cnt=0 and lcnt++ (saturating).
    - When lcnt transitions to LONG_PERIODS (and LONG_PERIODS>0): pulse LONG.
  - RWAIT: LEVEL stays 1.
    - If s=1: return to PRESSED, cnt=0; lcnt is kept and the long timing resumes.
    - Otherwise cnt++.
    - On the CNT_FULL-th consecutive s=0 sample: go to IDLE, set LEVEL=0, pulse RELEASE, cnt=0, lcnt=0.
  - Illegal state encoding: go to IDLE with all outputs 0.
- Latency, BTN held from before edge 0:
  - PRESS and LEVEL rise after edge SYNC_STAGES+CNT_FULL.
  - RELEASE behaves symmetrically.
  - LONG is high after edge SYNC_STAGES+CNT_FULL+LONG_PERIODS*CNT_FULL, provided there is no bounce.
- Pulse rules:
  - PRESS, RELEASE and LONG are each exactly one cycle wide.
  - PRESS and RELEASE are never asserted in the same cycle on the same channel.
  - LONG fires only after PRESS and before the matching RELEASE.
- CNT_FULL=1: a single stable sample qualifies.
- Channels with simultaneous events all assert their pulses in the same cycle.

Test Plan:
- CNT_FULL=10, SYNC_STAGES=2, N_CH=4, clean press on BTN[0] at edge 0 -> LEVEL[0] and PRESS[0] high after edge 12, PRESS[0] low after edge 13, other channels stay 0.
- Bounce BTN[1]: high 5 cycles, low 1, high 3, low -> no PRESS, LEVEL[1] stays 0. Then hold high 20 cycles -> PRESS after exactly 10 stable synced samples.
- LONG_PERIODS=3, hold BTN[2] 60 cycles -> PRESS after edge 12, single LONG after edge 42, no second LONG. Release -> RELEASE 12 cycles after the falling edge, LEVEL back to 0.
- Release bounce: while pressed, drop BTN[3] low 4 cycles then high -> no RELEASE, LEVEL stays 1, LONG timing resumes with lcnt preserved.
- POLARITY=4'b0001, BTN[0] idle high, driven low for 20 cycles -> PRESS[0] at the same latency as an active-high channel.
- Reset: assert RST_N=0 mid-PRESSED on all channels -> all outputs 0 asynchronously, no RELEASE. Release reset with buttons still held -> fresh PRESS after SYNC_STAGES+CNT_FULL edges.
